// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard control unit and its source decoder.
// It holds the RV32 opcodes whose source registers can take part in a load-use hazard.
package hazard_pkg;

  localparam logic [6:0] OP_ARIT  = 7'b0110011;
  localparam logic [6:0] OP_ARITI = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  typedef enum logic {
    HZ_IDLE    = 1'b0,
    HZ_LD_WAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_unit_src_decode.sv
// Maps an opcode to the register sources it reads.
// Any opcode not listed, including an unknown value, reads neither source.
module hazard_src_decode
  import hazard_pkg::*;
(
  input  logic [6:0] op_code_i,
  output logic       use_rs1_o,
  output logic       use_rs2_o
);

  // Opcode to source-usage lookup
  always_comb begin
    use_rs1_o = 1'b0;
    use_rs2_o = 1'b0;
    case (op_code_i)
      OP_ARIT, OP_SW, OP_BEQ: begin
        use_rs1_o = 1'b1;
        use_rs2_o = 1'b1;
      end
      OP_ARITI, OP_LW, OP_JALR: begin
        use_rs1_o = 1'b1;
        use_rs2_o = 1'b0;
      end
      default: begin
        use_rs1_o = 1'b0;
        use_rs2_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Load-use hazard stall, mispredict flush and saturating stall/flush counters for the 5-stage RV32 core.
// A stall lasts LOAD_LAT cycles. A mispredict flush overrides the stall and cancels any wait.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              MEMREAD_ID_EX,
  input  logic [REG_AW-1:0] ARD_ID_EX,
  input  logic [REG_AW-1:0] ARS1_IF_ID,
  input  logic [REG_AW-1:0] ARS2_IF_ID,
  input  logic [6:0]        OP_CODE,
  input  logic              BEQ_WRONG_PRED,
  output logic              STALL,
  output logic              MUX_SEL,
  output logic              FLUSH_IF_ID,
  output logic              FLUSH_ID_EX,
  output logic              BUSY,
  output logic [CNT_W-1:0]  STALL_CNT,
  output logic [CNT_W-1:0]  FLUSH_CNT
);

  localparam int WCNT_W = $clog2(LOAD_LAT) + 1;
  // The first stall cycle happens in IDLE, so the wait state covers the remaining LOAD_LAT-1 cycles.
  localparam logic [WCNT_W-1:0] WCNT_INIT = (LOAD_LAT > 1) ? WCNT_W'(LOAD_LAT - 2) : '0;

  hz_state_t          state_q, state_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic               use_rs1_s, use_rs2_s;
  logic               hit_s, stall_s, flush_s;

  hazard_src_decode u_src_decode (
    .op_code_i (OP_CODE),
    .use_rs1_o (use_rs1_s),
    .use_rs2_o (use_rs2_s)
  );

  assign hit_s = MEMREAD_ID_EX && (ARD_ID_EX != '0) &&
                 ((use_rs1_s && (ARD_ID_EX == ARS1_IF_ID)) ||
                  (use_rs2_s && (ARD_ID_EX == ARS2_IF_ID)));

  // Next-state logic; a mispredict wins over any stall
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    stall_s = 1'b0;
    flush_s = 1'b0;
    if (BEQ_WRONG_PRED) begin
      flush_s = 1'b1;
      state_d = HZ_IDLE;
      wcnt_d  = '0;
    end else begin
      case (state_q)
        HZ_IDLE: begin
          stall_s = hit_s;
          if (hit_s && (LOAD_LAT > 1)) begin
            state_d = HZ_LD_WAIT;
            wcnt_d  = WCNT_INIT;
          end else begin
            state_d = HZ_IDLE;
          end
        end
        HZ_LD_WAIT: begin
          stall_s = 1'b1;
          if (wcnt_q == '0) begin
            state_d = HZ_IDLE;
          end else begin
            wcnt_d = wcnt_q - WCNT_W'(1);
          end
        end
        default: begin
          state_d = HZ_IDLE;
          wcnt_d  = '0;
        end
      endcase
    end
  end

  // Saturating performance counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_s && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (flush_s && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // State, wait counter and performance counter registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= HZ_IDLE;
      wcnt_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Outputs are combinational and pipeline-facing, so they are gated low while reset is held
  assign STALL       = RST_N & stall_s;
  assign MUX_SEL     = RST_N & stall_s;
  assign FLUSH_IF_ID = RST_N & flush_s;
  assign FLUSH_ID_EX = RST_N & flush_s;
  assign BUSY        = RST_N & (state_q == HZ_LD_WAIT);
  assign STALL_CNT   = stall_cnt_q;
  assign FLUSH_CNT   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench: three configurations share one stimulus (A: LAT=1, B: LAT=3, C: LAT=1 with 4-bit counters).
module tb_hazard_ctrl_unit;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       memread = 1'b0;
  logic [4:0] ard = 5'd0, ars1 = 5'd0, ars2 = 5'd0;
  logic [6:0] opc = 7'd0;
  logic       beq = 1'b0;

  logic        a_st, a_mx, a_fi, a_fe, a_bz;
  logic        b_st, b_mx, b_fi, b_fe, b_bz;
  logic        c_st, c_mx, c_fi, c_fe, c_bz;
  logic [15:0] a_sc, a_fc, b_sc, b_fc;
  logic [3:0]  c_sc, c_fc;

  int total = 0;
  int bad = 0;

  typedef struct {
    int         dut;
    logic [4:0] exp;
    string      name;
  } sb_t;
  sb_t sbq[$];

  localparam logic [6:0] ARIT = 7'b0110011, ARITI = 7'b0010011, SW = 7'b0100011, LUI = 7'b0110111;

  always #5 CLK = ~CLK;

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(16)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .MEMREAD_ID_EX(memread), .ARD_ID_EX(ard), .ARS1_IF_ID(ars1),
    .ARS2_IF_ID(ars2), .OP_CODE(opc), .BEQ_WRONG_PRED(beq), .STALL(a_st), .MUX_SEL(a_mx),
    .FLUSH_IF_ID(a_fi), .FLUSH_ID_EX(a_fe), .BUSY(a_bz), .STALL_CNT(a_sc), .FLUSH_CNT(a_fc));

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(16)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .MEMREAD_ID_EX(memread), .ARD_ID_EX(ard), .ARS1_IF_ID(ars1),
    .ARS2_IF_ID(ars2), .OP_CODE(opc), .BEQ_WRONG_PRED(beq), .STALL(b_st), .MUX_SEL(b_mx),
    .FLUSH_IF_ID(b_fi), .FLUSH_ID_EX(b_fe), .BUSY(b_bz), .STALL_CNT(b_sc), .FLUSH_CNT(b_fc));

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(4)) dut_c (
    .CLK(CLK), .RST_N(RST_N), .MEMREAD_ID_EX(memread), .ARD_ID_EX(ard), .ARS1_IF_ID(ars1),
    .ARS2_IF_ID(ars2), .OP_CODE(opc), .BEQ_WRONG_PRED(beq), .STALL(c_st), .MUX_SEL(c_mx),
    .FLUSH_IF_ID(c_fi), .FLUSH_ID_EX(c_fe), .BUSY(c_bz), .STALL_CNT(c_sc), .FLUSH_CNT(c_fc));

  // Observed control outputs packed as {STALL, MUX_SEL, FLUSH_IF_ID, FLUSH_ID_EX, BUSY}
  function automatic logic [4:0] obs(input int d);
    case (d)
      0:       obs = {a_st, a_mx, a_fi, a_fe, a_bz};
      1:       obs = {b_st, b_mx, b_fi, b_fe, b_bz};
      default: obs = {c_st, c_mx, c_fi, c_fe, c_bz};
    endcase
  endfunction

  task automatic set_in(input logic m, input logic [4:0] rd, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [6:0] op, input logic b);
    memread = m; ard = rd; ars1 = r1; ars2 = r2; opc = op; beq = b;
  endtask

  task automatic expect_out(input int d, input logic [4:0] e, input string nm);
    sb_t s;
    s.dut = d; s.exp = e; s.name = nm;
    sbq.push_back(s);
  endtask

  // Let combinational outputs settle, drain the scoreboard, then advance one clock edge
  task automatic run_cycle();
    sb_t s;
    #1;
    while (sbq.size() > 0) begin
      s = sbq.pop_front();
      total++;
      if (obs(s.dut) !== s.exp) begin
        bad++;
        $display("FAIL %s dut%0d: got %b want %b", s.name, s.dut, obs(s.dut), s.exp);
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_cnt(input string nm, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    set_in(1'b1, 5'd5, 5'd5, 5'd7, ARIT, 1'b1);
    #2;
    for (int d = 0; d < 3; d++) expect_out(d, 5'b00000, "reset_outputs");
    run_cycle();
    chk_cnt("reset_a_stall_cnt", a_sc, 16'd0);
    chk_cnt("reset_c_flush_cnt", {12'd0, c_fc}, 16'd0);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 7'd0, 1'b0);
    RST_N = 1'b1;
  endtask

  task automatic test_lat1();
    set_in(1'b1, 5'd5, 5'd5, 5'd7, ARIT, 1'b0);
    expect_out(0, 5'b11000, "lat1_c1");
    expect_out(2, 5'b11000, "lat1_c1");
    run_cycle();
    set_in(1'b0, 5'd0, 5'd5, 5'd7, ARIT, 1'b0);
    expect_out(0, 5'b00000, "lat1_c2");
    expect_out(2, 5'b00000, "lat1_c2");
    run_cycle();
    chk_cnt("lat1_stall_cnt", a_sc, 16'd1);
  endtask

  task automatic test_lat3();
    test_reset();
    set_in(1'b1, 5'd5, 5'd5, 5'd7, ARIT, 1'b0);
    expect_out(1, 5'b11000, "lat3_c1");
    expect_out(0, 5'b11000, "lat3_c1");
    run_cycle();
    set_in(1'b0, 5'd0, 5'd5, 5'd7, ARIT, 1'b0);
    expect_out(1, 5'b11001, "lat3_c2");
    expect_out(0, 5'b00000, "lat3_c2");
    run_cycle();
    expect_out(1, 5'b11001, "lat3_c3");
    run_cycle();
    expect_out(1, 5'b00000, "lat3_c4");
    run_cycle();
    chk_cnt("lat3_stall_cnt", b_sc, 16'd3);
    chk_cnt("lat3_lat1_stall_cnt", a_sc, 16'd1);
  endtask

  task automatic test_filter();
    test_reset();
    set_in(1'b1, 5'd0, 5'd0, 5'd0, ARIT, 1'b0);
    expect_out(0, 5'b00000, "x0_dest");
    run_cycle();
    set_in(1'b1, 5'd5, 5'd5, 5'd5, LUI, 1'b0);
    expect_out(0, 5'b00000, "lui_no_src");
    run_cycle();
    set_in(1'b1, 5'd5, 5'd3, 5'd5, ARITI, 1'b0);
    expect_out(0, 5'b00000, "addi_rs2_ignored");
    run_cycle();
    set_in(1'b1, 5'd5, 5'd5, 5'd7, 7'bxxxxxxx, 1'b0);
    expect_out(0, 5'b00000, "unknown_opcode");
    run_cycle();
    set_in(1'b0, 5'd5, 5'd5, 5'd5, ARIT, 1'b0);
    expect_out(0, 5'b00000, "not_a_load");
    run_cycle();
    set_in(1'b1, 5'd5, 5'd2, 5'd5, SW, 1'b0);
    expect_out(0, 5'b11000, "sw_rs2_hazard");
    run_cycle();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 7'd0, 1'b0);
    chk_cnt("filter_stall_cnt", a_sc, 16'd1);
  endtask

  task automatic test_flush();
    test_reset();
    set_in(1'b1, 5'd5, 5'd5, 5'd7, ARIT, 1'b0);
    expect_out(1, 5'b11000, "flush_c1");
    run_cycle();
    set_in(1'b0, 5'd0, 5'd5, 5'd7, ARIT, 1'b1);
    expect_out(1, 5'b00111, "flush_c2");
    expect_out(0, 5'b00110, "flush_c2");
    run_cycle();
    set_in(1'b0, 5'd0, 5'd5, 5'd7, ARIT, 1'b0);
    expect_out(1, 5'b00000, "flush_c3");
    run_cycle();
    chk_cnt("flush_flush_cnt", b_fc, 16'd1);
    chk_cnt("flush_stall_cnt", b_sc, 16'd1);
  endtask

  task automatic test_reset_mid();
    test_reset();
    set_in(1'b1, 5'd5, 5'd5, 5'd7, ARIT, 1'b0);
    expect_out(1, 5'b11000, "rmid_c1");
    run_cycle();
    expect_out(1, 5'b11001, "rmid_c2");
    #1;
    total++;
    if (obs(1) !== 5'b11001) begin
      bad++;
      $display("FAIL rmid_before_drop: got %b want %b", obs(1), 5'b11001);
    end
    sbq.delete();
    #1;
    RST_N = 1'b0;
    #1;
    expect_out(1, 5'b00000, "rmid_async");
    expect_out(0, 5'b00000, "rmid_async");
    run_cycle();
    chk_cnt("rmid_stall_cnt", b_sc, 16'd0);
    RST_N = 1'b1;
    set_in(1'b0, 5'd0, 5'd1, 5'd2, ARIT, 1'b0);
    expect_out(1, 5'b00000, "rmid_after1");
    run_cycle();
    expect_out(1, 5'b00000, "rmid_after2");
    run_cycle();
  endtask

  task automatic test_saturate();
    test_reset();
    set_in(1'b1, 5'd5, 5'd5, 5'd7, ARIT, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (i == 14) chk_cnt("sat_before", {12'd0, c_sc}, 16'd14);
      expect_out(2, 5'b11000, "sat_cycle");
      run_cycle();
    end
    chk_cnt("sat_c_stall_cnt", {12'd0, c_sc}, 16'd15);
    chk_cnt("sat_a_stall_cnt", a_sc, 16'd20);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 7'd0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_lat1();
    test_lat3();
    test_filter();
    test_flush();
    test_reset_mid();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Parametrised successor of the pipeline hazard detector for the 5-stage RV32 core. It detects load-use hazards between ID/EX and IF/ID, with an opcode-aware source filter and an x0 exemption. It holds the stall for a configurable load latency using an FSM, and squashes IF/ID and ID/EX on a branch mispredict. It also keeps saturating stall and flush performance counters. It sits beside the ID stage and drives PC/IF-ID write enables, the ID/EX bubble mux and the flush lines.

Parameters:
REG_AW, 5, register address width
LOAD_LAT, 1, total stall cycles per load-use hazard (>=1); 1 matches the single-cycle-memory core
CNT_W, 16, width of each performance counter

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
MEMREAD_ID_EX  in  1  instruction in ID/EX is a load
ARD_ID_EX  in  REG_AW  destination register of ID/EX instruction
ARS1_IF_ID  in  REG_AW  rs1 field of IF/ID instruction
ARS2_IF_ID  in  REG_AW  rs2 field of IF/ID instruction
OP_CODE  in  7  opcode of IF/ID instruction
BEQ_WRONG_PRED  in  1  branch resolved in EX was mispredicted (1-cycle pulse)
STALL  out  1  freeze PC and IF/ID
MUX_SEL  out  1  insert bubble (zero controls) into ID/EX
FLUSH_IF_ID  out  1  squash IF/ID
FLUSH_ID_EX  out  1  squash ID/EX
BUSY  out  1  FSM not in IDLE
STALL_CNT  out  CNT_W  cycles with STALL=1, saturating
FLUSH_CNT  out  CNT_W  mispredict flush events, saturating

Behaviour:
- Source usage by OP_CODE: rs1 used for 0110011, 0010011, 0000011, 0100011, 1100011, 1100111. rs2 used for 0110011, 0100011, 1100011. Any other opcode uses neither, so no hazard.
- hit = MEMREAD_ID_EX & (ARD_ID_EX != 0) & ((use_rs1 & ARD_ID_EX==ARS1_IF_ID) | (use_rs2 & ARD_ID_EX==ARS2_IF_ID)).
- FSM states: IDLE, LD_WAIT. Down-counter wcnt is clog2(LOAD_LAT)+1 bits wide.
- IDLE: STALL=MUX_SEL=hit, combinational in the same cycle.
  - If hit and LOAD_LAT>1: go to LD_WAIT, wcnt=LOAD_LAT-2.
  - If LOAD_LAT==1: never leave IDLE. Behaviour is then identical to the single-cycle detector.
- LD_WAIT: STALL=MUX_SEL=1 unconditionally (the bubble now in ID/EX hides the load).
  - wcnt==0 -> IDLE, else decrement.
  - Each hazard therefore yields exactly LOAD_LAT stall cycles.
- Mispredict: BEQ_WRONG_PRED=1 -> FLUSH_IF_ID=FLUSH_ID_EX=1 the same cycle, combinational.
  - Flush has priority: STALL=MUX_SEL=0 that cycle.
  - Next state is IDLE from either state, aborting any LD_WAIT.
- BUSY=1 iff state==LD_WAIT.
- Counters:
  - STALL_CNT +1 on each cycle with STALL=1.
  - FLUSH_CNT +1 on each cycle with BEQ_WRONG_PRED=1.
  - Both hold at all-ones once saturated.
- Reset (RST_N low, asynchronous): state=IDLE, wcnt=0, counters=0.
  - All outputs are forced 0 while RST_N=0, regardless of inputs.
  - Reset asserted mid-LD_WAIT aborts the stall immediately.
  - After release, the first edge is evaluated from IDLE.
- X-free: unknown OP_CODE values are treated as using no sources.

Decomposition:
- Package hazard_pkg holds:
  - opcode localparams: OP_ARIT, OP_ARITI, OP_LW, OP_SW, OP_BEQ, OP_JALR
  - state enum hz_state_t {HZ_IDLE, HZ_LD_WAIT}
- One sub-module, hazard_src_decode: OP_CODE -> {use_rs1, use_rs2}. It is pure combinational and reused by the forwarding unit.
- Counters stay inline.

Test Plan:
- LOAD_LAT=1: lw x5, then add x6,x5,x7 in IF/ID -> STALL=MUX_SEL=1 for exactly 1 cycle, BUSY stays 0, STALL_CNT=1.
- LOAD_LAT=3: same pair -> STALL=1 for 3 consecutive cycles, BUSY=1 on cycles 2-3, then 0; STALL_CNT=3.
- x0 and filter:
  - lw x0 followed by add x1,x0,x0 -> no stall.
  - lw x5 followed by lui with rs2 field=5 -> no stall.
  - lw x5 followed by sw x5,0(x2) -> 1 stall.
- LOAD_LAT=3, BEQ_WRONG_PRED pulse in the 2nd stall cycle -> that cycle STALL=0 and FLUSH_IF_ID=FLUSH_ID_EX=1; next cycle IDLE with STALL=0; FLUSH_CNT=1.
- RST_N dropped mid-LD_WAIT (async, between edges) -> outputs go 0 immediately and counters read 0. After release with no hazard, STALL stays 0.
- CNT_W=4: 20 hazard cycles -> STALL_CNT saturates at 15 and holds.
